// File: rtl/vga_snapshot_scheduler.sv
// rtl/vga_snapshot_scheduler.sv - shares the mmio port between the processor and a per-frame sprite snapshot engine
// Snapshots both players' 5-word blocks on vsync fall and commits them to p1VGA/p2VGA together.
module vga_snapshot_scheduler #(
  parameter logic [12:0] BASE_P1 = 13'h1000,
  parameter logic [12:0] BASE_P2 = 13'h1008
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         vsync_n,
  input  logic         proc_req,
  input  logic [12:0]  proc_address,
  input  logic [31:0]  proc_data,
  input  logic         proc_wren,
  output logic [31:0]  proc_q,
  output logic [12:0]  mem_address,
  output logic [31:0]  mem_data,
  output logic         mem_wren,
  input  logic [31:0]  mem_q,
  output logic [159:0] p1VGA,
  output logic [159:0] p2VGA,
  output logic         busy,
  output logic [7:0]   frame_count,
  output logic [7:0]   overrun_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic        meta_q, sync_q, prev_q, fall_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  tag_q, tag_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [31:0] shadow_q [10];
  logic [159:0] p1_q, p2_q;

  logic        proc_own;
  logic        eng_issue;
  logic [12:0] eng_addr;

  assign proc_own  = proc_req | proc_wren;
  assign eng_issue = (state_q == S_FETCH) && !proc_own;
  assign eng_addr  = (idx_q < 4'd5) ? (BASE_P1 + {9'd0, idx_q})
                                    : (BASE_P2 + {9'd0, idx_q} - 13'd5);

  // A processor store always implies ownership, so mem_wren can follow proc_wren directly.
  assign mem_address   = eng_issue ? eng_addr : proc_address;
  assign mem_wren      = proc_wren;
  assign mem_data      = proc_data;
  assign proc_q        = mem_q;
  assign p1VGA         = p1_q;
  assign p2VGA         = p2_q;
  assign busy          = busy_q;
  assign frame_count   = frame_q;
  assign overrun_count = overrun_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    pending_d = 1'b0;
    busy_d    = busy_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (fall_q) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          idx_d   = 4'd0;
        end
      end
      S_FETCH: begin
        if (eng_issue) begin
          pending_d = 1'b1;
          tag_d     = idx_q;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd9) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_COMMIT;
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        frame_d = frame_q + 8'd1;
      end
    endcase
    if (fall_q && busy_q && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
  end

  // Sync flops reset high so a reset never manufactures a vsync fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= vsync_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      tag_q     <= 4'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= 8'd0;
      overrun_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

  // Read data arrives one cycle after its address, so capture uses the previous cycle's tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) shadow_q[i] <= 32'd0;
      p1_q <= 160'd0;
      p2_q <= 160'd0;
    end else begin
      if (pending_q) shadow_q[tag_q] <= mem_q;
      if (state_q == S_COMMIT) begin
        p1_q <= {shadow_q[4], shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
        p2_q <= {shadow_q[9], shadow_q[8], shadow_q[7], shadow_q[6], shadow_q[5]};
      end
    end
  end

endmodule
